// File: rtl/alu_shift_pkg.sv
// rtl/alu_shift_pkg.sv - shared types and helpers for the ALU shifters
package alu_shift_pkg;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} shl_state_t;

  function automatic logic [31:0] clamp_shift(input logic [31:0] amount, input logic [31:0] n);
    return (amount > n) ? n : amount;
  endfunction

endpackage

// File: rtl/left_shift_step.sv
// rtl/left_shift_step.sv - one combinational left-shift step with signed overflow detect
module left_shift_step #(
  parameter int N = 4
) (
  input  logic [N-1:0] step_in,
  output logic [N-1:0] step_out,
  output logic         ovf_step
);

  assign step_out = {step_in[N-2:0], 1'b0};
  // The sign changes on this step exactly when the top two bits differ.
  assign ovf_step = step_in[N-1] ^ step_in[N-2];

endmodule

// File: rtl/sequential_left_shifter.sv
// rtl/sequential_left_shifter.sv - multi-cycle left shifter, one bit per clock
// Signed overflow flag enabled by defining SHL_OVERFLOW_FLAG_EN; otherwise ovf is tied low.
module sequential_left_shifter
  import alu_shift_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] shift,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] y,
  output logic         ovf
);

  localparam int CW = $clog2(N + 1);

  shl_state_t    state_q, state_d;
  logic [N-1:0]  shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  y_q, y_d;
  logic [N-1:0]  step_out;
  logic          step_ovf;

  left_shift_step #(.N(N)) u_step (
    .step_in  (shreg_q),
    .step_out (step_out),
    .ovf_step (step_ovf)
  );

`ifdef SHL_OVERFLOW_FLAG_EN
  logic ovf_q, ovf_d;
  assign ovf = ovf_q;
`else
  logic unused_step_ovf;
  assign unused_step_ovf = step_ovf;
  assign ovf = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
`ifdef SHL_OVERFLOW_FLAG_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          shreg_d = a;
          cnt_d   = CW'(clamp_shift(32'(shift), 32'(N)));
`ifdef SHL_OVERFLOW_FLAG_EN
          ovf_d   = 1'b0;
`endif
          if (cnt_d == '0) begin
            state_d = S_DONE;
            y_d     = a;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        shreg_d = step_out;
        cnt_d   = cnt_q - CW'(1);
`ifdef SHL_OVERFLOW_FLAG_EN
        ovf_d   = ovf_q | step_ovf;
`endif
        // y is loaded on the edge that enters DONE, so it tracks done exactly.
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          y_d     = step_out;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
`ifdef SHL_OVERFLOW_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
`ifdef SHL_OVERFLOW_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign y    = y_q;

endmodule

// File: tb/tb_sequential_left_shifter.sv
// tb/tb_sequential_left_shifter.sv - self-checking bench for sequential_left_shifter (N=4)
module tb_sequential_left_shifter;

  localparam int N = 4;
`ifdef SHL_OVERFLOW_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] shift = '0;
  logic         busy, done, ovf;
  logic [N-1:0] y;

  int n_checks = 0;
  int n_pass = 0;

  sequential_left_shifter #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .shift (shift),
    .busy  (busy),
    .done  (done),
    .y     (y),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] va;
    logic [N-1:0] vshift;
    logic [N-1:0] ey;
    logic         eovf;
    int           elat;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference: y is a*2^k modulo 2^N; overflow when the signed result differs from signed a*2^k.
  function automatic void model(input logic [N-1:0] ma, input logic [N-1:0] ms,
                                output logic [N-1:0] my, output logic mo, output int lat);
    int k, ua, sa, wrapped, sy;
    k       = (int'(ms) > N) ? N : int'(ms);
    ua      = int'(ma);
    sa      = (ua >= 2**(N-1)) ? ua - 2**N : ua;
    wrapped = (ua * (2**k)) % (2**N);
    sy      = (wrapped >= 2**(N-1)) ? wrapped - 2**N : wrapped;
    my      = N'(wrapped);
    mo      = OVF_EN && ((sa * (2**k)) != sy);
    lat     = k + 1;
  endfunction

  task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] ts,
                        input logic [N-1:0] ey, input logic eo, input int elat, input string name);
    int done_cyc, ndone;
    logic [N-1:0] got_y;
    logic got_o, busy_ok;
    done_cyc = -1; ndone = 0; got_y = '0; got_o = 1'b0; busy_ok = 1'b1;
    @(negedge clk);
    start = 1'b1; a = ta; shift = ts;
    @(posedge clk);
    for (int c = 1; c <= elat + 2; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0; a = ~ta; shift = N'($urandom_range(0, 2**N - 1));
      end
      if (done) begin
        ndone++; done_cyc = c; got_y = y; got_o = ovf;
      end
      if (busy !== (c <= elat)) busy_ok = 1'b0;
    end
    chk({name, " done_cycle"}, done_cyc, elat);
    chk({name, " done_count"}, ndone, 1);
    chk({name, " y"}, int'(got_y), int'(ey));
    chk({name, " ovf"}, int'(got_o), int'(eo));
    chk({name, " busy_profile"}, int'(busy_ok), 1);
  endtask

  initial begin
    vec_t vecs[8];
    logic [N-1:0] my, ra, rs;
    logic mo;
    int lat, ndone, done_at;
    logic y_ok;

    vecs[0] = '{4'b0011, 4'd1,  4'b0110, 1'b0, 2};
    vecs[1] = '{4'b0011, 4'd2,  4'b1100, 1'b1, 3};
    vecs[2] = '{4'b1111, 4'd2,  4'b1100, 1'b0, 3};
    vecs[3] = '{4'b1000, 4'd1,  4'b0000, 1'b1, 2};
    vecs[4] = '{4'b0101, 4'd0,  4'b0101, 1'b0, 1};
    vecs[5] = '{4'b0101, 4'd4,  4'b0000, 1'b1, 5};
    vecs[6] = '{4'b0101, 4'd9,  4'b0000, 1'b1, 5};
    vecs[7] = '{4'b0000, 4'd15, 4'b0000, 1'b0, 5};

    repeat (3) @(negedge clk);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset y", int'(y), 0);
    chk("reset ovf", int'(ovf), 0);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].va, vecs[i].vshift, vecs[i].ey, vecs[i].eovf && OVF_EN, vecs[i].elat,
             $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      ra = N'($urandom_range(0, 2**N - 1));
      rs = N'($urandom_range(0, 2**N - 1));
      model(ra, rs, my, mo, lat);
      run_op(ra, rs, my, mo, lat, $sformatf("rand%0d", i));
    end

    // Second start during busy must be ignored.
    model(4'b0001, 4'd3, my, mo, lat);
    @(negedge clk);
    start = 1'b1; a = 4'b0001; shift = 4'd3;
    @(posedge clk);
    ndone = 0; done_at = -1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) begin start = 1'b1; a = 4'b1111; shift = 4'd1; end
      if (c == 2) start = 1'b0;
      if (done) begin
        ndone++; done_at = c;
        chk("ignore_start y", int'(y), int'(my));
        chk("ignore_start ovf", int'(ovf), int'(mo));
      end
    end
    chk("ignore_start done_count", ndone, 1);
    chk("ignore_start done_cycle", done_at, 4);

    // Reset in the middle of an operation discards it.
    @(negedge clk);
    start = 1'b1; a = 4'b0011; shift = 4'd3;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    chk("midreset busy", int'(busy), 0);
    chk("midreset y", int'(y), 0);
    chk("midreset ovf", int'(ovf), 0);
    chk("midreset done", int'(done), 0);
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midreset no_done", ndone, 0);
    run_op(4'b0011, 4'd1, 4'b0110, 1'b0, 2, "after_reset");

    // Start held high: one IDLE cycle between runs, y stable between done pulses.
    @(negedge clk);
    start = 1'b1; a = 4'b0011; shift = 4'd1;
    @(posedge clk);
    ndone = 0; y_ok = 1'b1; done_at = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) a = 4'b0101;
      if (c == 9) start = 1'b0;
      if (done !== (c == 2 || c == 5 || c == 8)) done_at++;
      if (done) ndone++;
      if (c >= 2 && y !== ((c < 5) ? 4'b0110 : 4'b1010)) y_ok = 1'b0;
    end
    chk("b2b done_pattern_errors", done_at, 0);
    chk("b2b done_count", ndone, 3);
    chk("b2b y_stable", int'(y_ok), 1);
    repeat (4) @(negedge clk);
    chk("b2b final idle", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
